// File: rtl/ir_pkg.sv
// Shared definitions for the IR letter link: receiver FSM states, default
// pulse-distance timing windows (clk_in cycles at 100 MHz) and a window helper.
package ir_pkg;

    localparam int COUNT_W = 20;

    localparam int DEF_MESSAGE_LENGTH  = 5;
    localparam int DEF_START_MARK_MIN  = 720_000;
    localparam int DEF_START_MARK_MAX  = 1_080_000;
    localparam int DEF_START_SPACE_MIN = 360_000;
    localparam int DEF_START_SPACE_MAX = 540_000;
    localparam int DEF_BIT_MARK_MIN    = 45_000;
    localparam int DEF_BIT_MARK_MAX    = 67_500;
    localparam int DEF_ZERO_SPACE_MIN  = 45_000;
    localparam int DEF_ZERO_SPACE_MAX  = 67_500;
    localparam int DEF_ONE_SPACE_MIN   = 135_000;
    localparam int DEF_ONE_SPACE_MAX   = 202_500;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_MARK,
        ST_START_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_DONE,
        ST_ABORT
    } ir_state_e;

    // Inclusive window test on a measured phase length.
    function automatic logic in_window(input int len, input int lo, input int hi);
        return (len >= lo) && (len <= hi);
    endfunction

endpackage

// File: rtl/ir_sync_edge.sv
// Brings the asynchronous photoreceiver output into clk_in and flags its edges.
// Flops reset to 1 (idle line) so leaving reset never looks like a mark start.
module ir_sync_edge (
    input  logic clk_in,
    input  logic rst_in,
    input  logic signal_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // Next values for the synchronizer chain and the edge-delay register.
    always_comb begin
        s1_d = signal_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer and delay registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level_out = s2_q;
    assign rise_out  = s2_q & ~s3_q;
    assign fall_out  = ~s2_q & s3_q;

endmodule

// File: rtl/ir_receiver.sv
// Pulse-distance IR frame decoder: start mark/space, MESSAGE_LENGTH bits sent
// LSB first, then a stop mark. Valid frames produce a one-cycle data strobe,
// malformed or truncated frames a one-cycle error strobe.
module ir_receiver
    import ir_pkg::*;
#(
    parameter int MESSAGE_LENGTH  = DEF_MESSAGE_LENGTH,
    parameter int START_MARK_MIN  = DEF_START_MARK_MIN,
    parameter int START_MARK_MAX  = DEF_START_MARK_MAX,
    parameter int START_SPACE_MIN = DEF_START_SPACE_MIN,
    parameter int START_SPACE_MAX = DEF_START_SPACE_MAX,
    parameter int BIT_MARK_MIN    = DEF_BIT_MARK_MIN,
    parameter int BIT_MARK_MAX    = DEF_BIT_MARK_MAX,
    parameter int ZERO_SPACE_MIN  = DEF_ZERO_SPACE_MIN,
    parameter int ZERO_SPACE_MAX  = DEF_ZERO_SPACE_MAX,
    parameter int ONE_SPACE_MIN   = DEF_ONE_SPACE_MIN,
    parameter int ONE_SPACE_MAX   = DEF_ONE_SPACE_MAX
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      signal_in,
    output logic [MESSAGE_LENGTH-1:0] data_out,
    output logic                      data_valid_out,
    output logic                      busy_out,
    output logic                      error_out
);

    localparam int                 BIT_W     = $clog2(MESSAGE_LENGTH + 1);
    localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(MESSAGE_LENGTH);
    localparam logic [COUNT_W-1:0] COUNT_SAT = {COUNT_W{1'b1}};

    logic level, rise, fall, edge_seen;

    ir_state_e                 state_q,   state_d;
    logic [COUNT_W-1:0]        count_q,   count_d;
    logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [MESSAGE_LENGTH-1:0] shift_q,   shift_d;
    logic [MESSAGE_LENGTH-1:0] data_q,    data_d;
    logic                      valid_q,   valid_d;
    logic                      err_pend_q, err_pend_d;
    logic                      error_q,   error_d;

    int   len;
    int   limit;
    logic timed;
    logic timeout;

    ir_sync_edge u_sync (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .signal_in (signal_in),
        .level_out (level),
        .rise_out  (rise),
        .fall_out  (fall)
    );

    assign edge_seen = rise | fall;

    // Duration counter: restarts on every edge and saturates on a quiet line.
    always_comb begin
        if (edge_seen) begin
            count_d = '0;
        end else if (count_q == COUNT_SAT) begin
            count_d = count_q;
        end else begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    // Phase length if it ended this cycle, and the ceiling for the current phase.
    // With the default timing the start-mark ceiling lies above the saturated
    // length, so an over-long start mark simply waits for its rising edge.
    always_comb begin
        len   = int'(count_q) + 1;
        limit = 0;
        timed = 1'b0;
        case (state_q)
            ST_START_MARK:  begin limit = START_MARK_MAX;  timed = 1'b1; end
            ST_START_SPACE: begin limit = START_SPACE_MAX; timed = 1'b1; end
            ST_BIT_MARK:    begin limit = BIT_MARK_MAX;    timed = 1'b1; end
            ST_BIT_SPACE:   begin limit = ONE_SPACE_MAX;   timed = 1'b1; end
            default:        ;
        endcase
        // No edge now means the phase is at least len+1 long.
        timeout = timed && !edge_seen && (len >= limit);
    end

    // Frame FSM: next state, bit assembly and output strobes.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_pend_d = 1'b0;
        error_d    = err_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (fall) state_d = ST_START_MARK;
            end
            ST_START_MARK: begin
                if (edge_seen) begin
                    if (in_window(len, START_MARK_MIN, START_MARK_MAX)) begin
                        state_d = ST_START_SPACE;
                    end else begin
                        state_d    = ST_ABORT;
                        err_pend_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d    = ST_ABORT;
                    err_pend_d = 1'b1;
                end
            end
            ST_START_SPACE: begin
                if (edge_seen) begin
                    if (in_window(len, START_SPACE_MIN, START_SPACE_MAX)) begin
                        state_d   = ST_BIT_MARK;
                        bit_cnt_d = '0;
                    end else begin
                        state_d    = ST_ABORT;
                        err_pend_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d    = ST_ABORT;
                    err_pend_d = 1'b1;
                end
            end
            ST_BIT_MARK: begin
                if (edge_seen) begin
                    if (in_window(len, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                        // After all payload bits the mark is the stop mark.
                        state_d = (bit_cnt_q == LAST_BIT) ? ST_DONE : ST_BIT_SPACE;
                    end else begin
                        state_d    = ST_ABORT;
                        err_pend_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d    = ST_ABORT;
                    err_pend_d = 1'b1;
                end
            end
            ST_BIT_SPACE: begin
                if (edge_seen) begin
                    if (in_window(len, ZERO_SPACE_MIN, ZERO_SPACE_MAX)) begin
                        shift_d   = {1'b0, shift_q[MESSAGE_LENGTH-1:1]};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        state_d   = ST_BIT_MARK;
                    end else if (in_window(len, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                        shift_d   = {1'b1, shift_q[MESSAGE_LENGTH-1:1]};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        state_d   = ST_BIT_MARK;
                    end else begin
                        state_d    = ST_ABORT;
                        err_pend_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d    = ST_ABORT;
                    err_pend_d = 1'b1;
                end
            end
            ST_DONE: begin
                data_d  = shift_q;
                valid_d = 1'b1;
                // A mark starting right away is the next frame; keep it.
                state_d = fall ? ST_START_MARK : ST_IDLE;
            end
            ST_ABORT: begin
                if (level) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_pend_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_pend_q <= err_pend_d;
            error_q    <= error_d;
        end
    end

    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign busy_out       = (state_q != ST_IDLE);
    assign error_out      = error_q;

endmodule
